// File: rtl/wishbone_pkg.sv
// Shared Wishbone definitions: mailbox register offsets,
// STATUS/CTRL bit positions and the slave ack FSM state type.
package wishbone_pkg;

  localparam logic [19:0] MBOX_DATA   = 20'h0;
  localparam logic [19:0] MBOX_STATUS = 20'h4;
  localparam logic [19:0] MBOX_CTRL   = 20'h8;
  localparam logic [19:0] MBOX_FLUSH  = 20'hC;

  localparam int ST_EMPTY     = 0;
  localparam int ST_FULL      = 1;
  localparam int ST_COUNT_LSB = 8;

  localparam int CTRL_IRQ_EN  = 0;
  localparam int CTRL_THR_LSB = 8;

  typedef enum logic {
    IDLE,
    RESP
  } ack_state_e;

endpackage

// File: rtl/wb_mailbox_fifo.sv
// Word FIFO behind the mailbox: synchronous push/pop/flush,
// occupancy count, full/empty flags and head-of-queue data.
module wb_mailbox_fifo #(
  parameter int DW    = 32,
  parameter int DEPTH = 16,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic          flush_i,
  input  logic [DW-1:0] wdata_i,
  output logic [DW-1:0] head_o,
  output logic [CW-1:0] count_o,
  output logic          full_o,
  output logic          empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wp_q, wp_d;
  logic [AW-1:0] rp_q, rp_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Next pointers/count; pointers wrap by natural overflow.
  always_comb begin
    wp_d  = wp_q;
    rp_d  = rp_q;
    cnt_d = cnt_q;
    if (flush_i) begin
      wp_d  = '0;
      rp_d  = '0;
      cnt_d = '0;
    end else begin
      if (push_i) wp_d = wp_q + 1'b1;
      if (pop_i)  rp_d = rp_q + 1'b1;
      if (push_i && !pop_i) cnt_d = cnt_q + 1'b1;
      if (pop_i && !push_i) cnt_d = cnt_q - 1'b1;
    end
  end

  // Pointer and count state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage array; contents need no reset.
  always_ff @(posedge clk) begin
    if (push_i && !flush_i) mem_q[wp_q] <= wdata_i;
  end

  assign head_o  = mem_q[rp_q];
  assign count_o = cnt_q;
  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);

endmodule

// File: rtl/wb_mailbox_slave.sv
// Wishbone B.3 mailbox slave: register decode, ack FSM, CTRL, irq.
// Define WB_MAILBOX_RTY_EN to retry (not error) full/empty DATA beats.
module wb_mailbox_slave
  import wishbone_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int DEPTH      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_cyc,
  input  logic                  s_stb,
  input  logic                  s_we,
  input  logic [ADDR_WIDTH-1:0] s_addr,
  input  logic [7:0]            s_sel,
  input  logic [DATA_WIDTH-1:0] s_wdata,
  input  logic [2:0]            s_cti,
  input  logic [1:0]            s_bte,
  output logic [DATA_WIDTH-1:0] s_rdata,
  output logic                  s_ack,
  output logic                  s_err,
  output logic                  s_rty,
  output logic                  irq
);

  localparam int CW = $clog2(DEPTH) + 1;

  ack_state_e state_q;
  logic       ack_q, err_q;
  logic       irq_q, irq_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic       en_q, en_d;
  logic [7:0] thr_q, thr_d;

  logic [DATA_WIDTH-1:0] head;
  logic [CW-1:0] count;
  logic full, empty;
  logic push, pop, flush;
  logic ack_c, err_c, busy_c;
  logic [DATA_WIDTH-1:0] status;
  logic [19:0] a;
  logic beat, bad_addr;

  assign beat     = s_cyc & s_stb & (state_q == IDLE);
  assign a        = {s_addr[19:2], 2'b00};
  assign bad_addr = |s_addr[19:4];

  // STATUS image: count zero-extended, flags in low bits.
  always_comb begin
    status = '0;
    status[ST_COUNT_LSB +: CW] = count;
    status[ST_FULL]  = full;
    status[ST_EMPTY] = empty;
  end

  // Beat decode: termination kind, FIFO strobes, CTRL update.
  always_comb begin
    ack_c   = 1'b0;
    err_c   = 1'b0;
    busy_c  = 1'b0;
    push    = 1'b0;
    pop     = 1'b0;
    flush   = 1'b0;
    rdata_d = '0;
    en_d    = en_q;
    thr_d   = thr_q;
    if (beat) begin
      unique case (1'b1)
        bad_addr: err_c = 1'b1;
        a == MBOX_DATA: begin
          if (s_we) begin
            if (s_sel[3:0] != 4'hF) err_c = 1'b1;
            else if (full) busy_c = 1'b1;
            else begin
              push  = 1'b1;
              ack_c = 1'b1;
            end
          end else if (empty) begin
            busy_c = 1'b1;
          end else begin
            pop     = 1'b1;
            ack_c   = 1'b1;
            rdata_d = head;
          end
        end
        a == MBOX_STATUS: begin
          err_c   = s_we;
          ack_c   = !s_we;
          rdata_d = s_we ? '0 : status;
        end
        a == MBOX_CTRL: begin
          ack_c = 1'b1;
          if (s_we) begin
            if (s_sel[0]) en_d  = s_wdata[CTRL_IRQ_EN];
            if (s_sel[1]) thr_d = s_wdata[CTRL_THR_LSB +: 8];
          end else begin
            rdata_d[CTRL_IRQ_EN]       = en_q;
            rdata_d[CTRL_THR_LSB +: 8] = thr_q;
          end
        end
        default: begin
          err_c = !s_we;
          ack_c = s_we;
          flush = s_we & s_wdata[0];
        end
      endcase
    end
  end

  assign irq_d = en_q & (9'(count) >= {1'b0, thr_q}) & (thr_q != 8'd0);

  // Ack FSM with registered terminations, read data, CTRL and irq.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      en_q    <= 1'b0;
      thr_q   <= '0;
      irq_q   <= 1'b0;
    end else begin
      state_q <= beat ? RESP : IDLE;
      ack_q   <= ack_c;
`ifdef WB_MAILBOX_RTY_EN
      err_q   <= err_c;
`else
      err_q   <= err_c | busy_c;
`endif
      rdata_q <= rdata_d;
      en_q    <= en_d;
      thr_q   <= thr_d;
      irq_q   <= irq_d;
    end
  end

`ifdef WB_MAILBOX_RTY_EN
  logic rty_q;

  // Retry termination for full-write / empty-read beats.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rty_q <= 1'b0;
    else     rty_q <= busy_c;
  end

  assign s_rty = rty_q;
`else
  assign s_rty = 1'b0;
`endif

  wb_mailbox_fifo #(
    .DW    (DATA_WIDTH),
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (flush),
    .wdata_i (s_wdata),
    .head_o  (head),
    .count_o (count),
    .full_o  (full),
    .empty_o (empty)
  );

  logic unused_in;
  assign unused_in = ^{s_cti, s_bte, s_addr, s_sel, s_wdata};

  assign s_rdata = rdata_q;
  assign s_ack   = ack_q;
  assign s_err   = err_q;
  assign irq     = irq_q;

endmodule

// File: tb/tb_wb_mailbox_slave.sv
// Directed bench for wb_mailbox_slave (DEPTH=16).
// Single-beat Wishbone accesses with hand-computed expectations.
module tb_wb_mailbox_slave;

  logic        clk = 1'b0;
  logic        rst;
  logic        s_cyc, s_stb, s_we;
  logic [31:0] s_addr;
  logic [7:0]  s_sel;
  logic [31:0] s_wdata;
  logic [2:0]  s_cti;
  logic [1:0]  s_bte;
  logic [31:0] s_rdata;
  logic        s_ack, s_err, s_rty, irq;

  int errors = 0;
  int checks = 0;

  logic [31:0] rd;
  logic        ak, er, ry, iq;

  wb_mailbox_slave #(
    .DATA_WIDTH (32),
    .ADDR_WIDTH (32),
    .DEPTH      (16)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .s_cyc   (s_cyc),
    .s_stb   (s_stb),
    .s_we    (s_we),
    .s_addr  (s_addr),
    .s_sel   (s_sel),
    .s_wdata (s_wdata),
    .s_cti   (s_cti),
    .s_bte   (s_bte),
    .s_rdata (s_rdata),
    .s_ack   (s_ack),
    .s_err   (s_err),
    .s_rty   (s_rty),
    .irq     (irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One beat: drive at negedge, sample #1 after the sampling edge,
  // then release and let the FSM return to IDLE.
  task automatic wb(input logic we, input logic [31:0] adr,
                    input logic [7:0] sel, input logic [31:0] wd,
                    output logic [31:0] r, output logic a,
                    output logic e, output logic y, output logic i);
    @(negedge clk);
    s_cyc = 1'b1; s_stb = 1'b1; s_we = we;
    s_addr = adr; s_sel = sel; s_wdata = wd;
    @(posedge clk);
    #1;
    r = s_rdata; a = s_ack; e = s_err; y = s_rty; i = irq;
    s_cyc = 1'b0; s_stb = 1'b0; s_we = 1'b0;
    @(posedge clk);
  endtask

  // Expected terminations for full-write / empty-read beats.
`ifdef WB_MAILBOX_RTY_EN
  localparam logic BUSY_ERR = 1'b0;
  localparam logic BUSY_RTY = 1'b1;
`else
  localparam logic BUSY_ERR = 1'b1;
  localparam logic BUSY_RTY = 1'b0;
`endif

  initial begin
    rst = 1'b1;
    s_cyc = 0; s_stb = 0; s_we = 0; s_addr = 0;
    s_sel = 0; s_wdata = 0; s_cti = 0; s_bte = 0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_ack", {31'b0, s_ack}, 32'd0);
    chk("rst_err", {31'b0, s_err}, 32'd0);
    chk("rst_rty", {31'b0, s_rty}, 32'd0);
    chk("rst_irq", {31'b0, irq}, 32'd0);
    chk("rst_rdata", s_rdata, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    wb(0, 32'h4, 8'hF, 0, rd, ak, er, ry, iq);
    chk("st0_ack", {31'b0, ak}, 32'd1);
    chk("st0_val", rd, 32'h1);
    chk("st0_irq", {31'b0, iq}, 32'd0);

    for (int k = 1; k <= 3; k++) begin
      wb(1, 32'h0, 8'hF, 32'hA5A5_0000 + k, rd, ak, er, ry, iq);
      chk("push3_ack", {31'b0, ak}, 32'd1);
    end
    wb(0, 32'h4, 8'hF, 0, rd, ak, er, ry, iq);
    chk("st3", rd, 32'h0000_0300);
    for (int k = 1; k <= 3; k++) begin
      wb(0, 32'h0, 8'hF, 0, rd, ak, er, ry, iq);
      chk("pop3_ack", {31'b0, ak}, 32'd1);
      chk("pop3_val", rd, 32'hA5A5_0000 + k);
    end
    wb(0, 32'h4, 8'hF, 0, rd, ak, er, ry, iq);
    chk("st_after_pop", rd, 32'h1);

    for (int k = 0; k < 16; k++) begin
      wb(1, 32'h0, 8'hF, 32'h100 + k, rd, ak, er, ry, iq);
      chk("fill_ack", {31'b0, ak}, 32'd1);
    end
    wb(0, 32'h4, 8'hF, 0, rd, ak, er, ry, iq);
    chk("st_full", rd, 32'h0000_1002);
    wb(1, 32'h0, 8'hF, 32'hDEAD, rd, ak, er, ry, iq);
    chk("ovf_ack", {31'b0, ak}, 32'd0);
    chk("ovf_err", {31'b0, er}, {31'b0, BUSY_ERR});
    chk("ovf_rty", {31'b0, ry}, {31'b0, BUSY_RTY});
    wb(0, 32'h4, 8'hF, 0, rd, ak, er, ry, iq);
    chk("st_full2", rd, 32'h0000_1002);
    wb(0, 32'h0, 8'hF, 0, rd, ak, er, ry, iq);
    chk("full_pop", rd, 32'h100);
    wb(1, 32'hC, 8'hF, 32'h1, rd, ak, er, ry, iq);
    chk("flush_ack", {31'b0, ak}, 32'd1);
    wb(0, 32'h4, 8'hF, 0, rd, ak, er, ry, iq);
    chk("st_flushed", rd, 32'h1);

    wb(0, 32'h0, 8'hF, 0, rd, ak, er, ry, iq);
    chk("unf_ack", {31'b0, ak}, 32'd0);
    chk("unf_err", {31'b0, er}, {31'b0, BUSY_ERR});
    chk("unf_rty", {31'b0, ry}, {31'b0, BUSY_RTY});
    wb(0, 32'h4, 8'hF, 0, rd, ak, er, ry, iq);
    chk("st_unf", rd, 32'h1);

    wb(1, 32'h8, 8'hF, 32'h0000_0201, rd, ak, er, ry, iq);
    chk("ctrl_ack", {31'b0, ak}, 32'd1);
    wb(0, 32'h8, 8'hF, 0, rd, ak, er, ry, iq);
    chk("ctrl_rd", rd, 32'h0000_0201);
    wb(1, 32'h0, 8'hF, 32'h11, rd, ak, er, ry, iq);
    chk("irq_p1", {31'b0, iq}, 32'd0);
    wb(1, 32'h0, 8'hF, 32'h22, rd, ak, er, ry, iq);
    chk("irq_at_ack", {31'b0, iq}, 32'd0);
    #1;
    chk("irq_rise", {31'b0, irq}, 32'd1);
    wb(1, 32'hC, 8'hF, 32'h1, rd, ak, er, ry, iq);
    chk("irq_at_flush", {31'b0, iq}, 32'd1);
    #1;
    chk("irq_fall", {31'b0, irq}, 32'd0);

    wb(0, 32'h10, 8'hF, 0, rd, ak, er, ry, iq);
    chk("bad_addr_err", {30'b0, ak, er}, 32'b01);
    wb(1, 32'h0, 8'h3, 32'h33, rd, ak, er, ry, iq);
    chk("sel_err", {30'b0, ak, er}, 32'b01);
    wb(1, 32'h4, 8'hF, 0, rd, ak, er, ry, iq);
    chk("wr_status_err", {30'b0, ak, er}, 32'b01);
    wb(0, 32'hC, 8'hF, 0, rd, ak, er, ry, iq);
    chk("rd_flush_err", {30'b0, ak, er}, 32'b01);
    wb(0, 32'h4, 8'hF, 0, rd, ak, er, ry, iq);
    chk("st_after_err", rd, 32'h1);

    @(negedge clk);
    s_cyc = 1'b1; s_stb = 1'b1; s_we = 1'b1;
    s_addr = 32'h0; s_sel = 8'hF; s_wdata = 32'h77;
    @(posedge clk);
    #1;
    chk("resp_ack", {31'b0, s_ack}, 32'd1);
    rst = 1'b1;
    #1;
    chk("rst_drop_ack", {31'b0, s_ack}, 32'd0);
    s_cyc = 1'b0; s_stb = 1'b0; s_we = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    wb(0, 32'h4, 8'hF, 0, rd, ak, er, ry, iq);
    chk("st_after_rst", rd, 32'h1);
    wb(0, 32'h8, 8'hF, 0, rd, ak, er, ry, iq);
    chk("ctrl_after_rst", rd, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wb_mailbox_slave.md
# wb_mailbox_slave

Wishbone B.3 slave that receives one per-slave strobe from the bus syscon and implements a word-wide mailbox FIFO: bus writes push words, bus reads pop them, and a status/control register pair exposes occupancy and a threshold interrupt. It sits directly downstream of the syscon and drives one index of the syscon's slave-output arrays (`s_rdata`, `s_ack`, `s_err`, `s_rty`) and one bit of the interrupt vector.

## Interface
- `DATA_WIDTH`, default 32: data bus width.
- `ADDR_WIDTH`, default 32: address bus width; only `s_addr[19:0]` is decoded.
- `DEPTH`, default 16: FIFO depth in words; must be a power of two, 2..256.
- `clk` in 1: bus clock.
- `rst` in 1: asynchronous, active-high reset.
- `s_cyc` in 1: bus cycle active.
- `s_stb` in 1: this slave's strobe, i.e. its select.
- `s_we` in 1: 1 = write, 0 = read.
- `s_addr` in ADDR_WIDTH: byte address.
- `s_sel` in 8: byte enables; only `[3:0]` are used.
- `s_wdata` in DATA_WIDTH: write data.
- `s_cti` in 3, `s_bte` in 2: accepted and ignored.
- `s_rdata` out DATA_WIDTH: read data, valid while `s_ack` is high.
- `s_ack` out 1: normal termination.
- `s_err` out 1: error termination.
- `s_rty` out 1: retry termination.
- `irq` out 1: level interrupt to the syscon vector.

## Operation
- Register map is decoded on `s_addr[19:2]`:
  - 0x0 DATA: write pushes, read pops.
  - 0x4 STATUS (RO): `[15:8]` count, `[1]` full, `[0]` empty.
  - 0x8 CTRL (RW): `[0]` irq_en, `[15:8]` threshold.
  - 0xC FLUSH (WO): writing `[0]`=1 empties the FIFO.
- A beat is a cycle where `s_cyc & s_stb` is high and no termination is currently being driven.
- Exactly one of `s_ack`/`s_err`/`s_rty` is asserted, for one cycle, on the clock after the beat is sampled.
- Error termination (`s_err`) on any of:
  - address `[19:4]` nonzero;
  - write to STATUS;
  - read of FLUSH;
  - DATA write with `s_sel[3:0]` != 4'hF.
- DATA write when full, or DATA read when empty: termination per Configuration; FIFO and pointers are unchanged.
- DATA read: `s_rdata` = head word, and the pop takes effect on the same edge that raises `s_ack`.
- Reads of other registers return zero-extended values; unused bits read 0.
- Block transfers (`s_stb` held high): each beat is terminated separately, giving at most one termination every 2 cycles.
- FLUSH clears the pointers and count on its ack edge; CTRL is unaffected.
- `irq` = irq_en & (count >= threshold) & (threshold != 0), registered.
- Count is log2(DEPTH)+1 bits wide, zero-extended into STATUS.
- Pointers wrap modulo DEPTH.

## Timing
- Reset values: `s_ack`, `s_err`, `s_rty`, `irq` = 0; `s_rdata` = 0; FIFO empty; CTRL = 0.
- Reset asserted mid-cycle:
  - all outputs go to reset values immediately (asynchronous);
  - the in-flight beat is lost and is not pushed or popped.
- Latency from sampled beat to termination: 1 cycle.
- If `s_stb` drops before termination, no termination is issued and no side effect occurs.
- `irq` follows a count or CTRL change by 1 cycle.
- Ack FSM states:
  - IDLE → RESP on a beat;
  - RESP → IDLE unconditionally.
  - No beat is sampled in RESP.

## Configuration
- `WB_MAILBOX_RTY_EN` defined: a write when full or a read when empty terminates with `s_rty`.
- Undefined: the same cases terminate with `s_err`, and `s_rty` is tied to 0.

## Structure
- Add to `wishbone_pkg`:
  - register offset constants `MBOX_DATA`, `MBOX_STATUS`, `MBOX_CTRL`, `MBOX_FLUSH`;
  - STATUS/CTRL bit-position constants;
  - `typedef enum {IDLE, RESP}` for the ack FSM.
- One sub-module, `wb_mailbox_fifo`:
  - synchronous push/pop/flush, count, full, empty, head data;
  - asynchronous reset.
- The top level holds the decode, the ack FSM, CTRL and irq.

## Test plan
- Reset, then read STATUS → `s_ack` after 1 cycle, `s_rdata` = 0x0000_0001 (empty); `irq` = 0.
- Write 0xA5A5_0001..0xA5A5_0003 to DATA, then read DATA three times → the three words in order; STATUS count reads 3, then 0.
- DEPTH=16:
  - push 16 words → STATUS = 0x0000_1002;
  - a 17th write → `s_rty` (macro on) or `s_err` (off);
  - a read returns the first word.
- Read DATA when empty → `s_rty`/`s_err` per macro, and STATUS stays 0x1.
- CTRL = 0x0000_0201 (threshold 2, irq_en), push 2 words:
  - `irq` rises 1 cycle after the second ack;
  - FLUSH write → `irq` low 1 cycle later.
- Address 0x0000_0010, or DATA write with `s_sel` = 4'h3 → `s_err`, FIFO unchanged. Assert `rst` during the RESP cycle → `s_ack` drops immediately and the FIFO is empty.
